// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: timed column scan of a 4x4 active-low matrix keypad with
// press/release debouncing and a valid/ready key-event output.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held
);

    typedef enum logic [1:0] {StScan, StDeb, StPress, StHold} state_e;

    localparam logic [15:0] DivLast = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DebN    = 4'(DEBOUNCE);
    localparam logic [3:0]  KpcInit = 4'b0111;

    logic [3:0]  sync1_q, rs_q;
    logic [15:0] div_q, div_d;
    state_e      state_q, state_d;
    logic [3:0]  kpc_q, kpc_d;
    logic [3:0]  row_l_q, row_l_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_held_q, key_held_d;

    logic       tick;
    logic       row_ok;
    logic       kpc_ok;
    logic       rel_done;
    logic [3:0] rcnt_upd;
    logic [3:0] kpc_rot;

    // Bit position of the single low bit of a one-cold pattern.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    assign tick    = (div_q == DivLast);
    assign row_ok  = ($countones(~rs_q) == 1);
    assign kpc_ok  = kpc_q inside {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    assign kpc_rot = {kpc_q[0], kpc_q[3:1]};

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 4'hF;
            rs_q    <= 4'hF;
        end else begin
            sync1_q <= kpr;
            rs_q    <= sync1_q;
        end
    end

    // Next-state logic: scan/debounce on ticks, handshake on every cycle.
    always_comb begin
        div_d       = tick ? 16'd0 : div_q + 16'd1;
        state_d     = state_q;
        kpc_d       = kpc_q;
        row_l_d     = row_l_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        key_held_d  = key_held_q;

        // Release counter saturates so a long release never wraps.
        rcnt_upd = rcnt_q;
        if (tick) begin
            if (rs_q == 4'hF) rcnt_upd = (rcnt_q == DebN) ? rcnt_q : rcnt_q + 4'd1;
            else              rcnt_upd = 4'd0;
        end
        rel_done = tick && (rcnt_upd == DebN);

        if (!kpc_ok) begin
            state_d = StScan;
            kpc_d   = KpcInit;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                StScan: begin
                    if (tick) begin
                        if (row_ok) begin
                            row_l_d = rs_q;
                            cnt_d   = 4'd1;
                            if (DebN == 4'd1) begin
                                state_d     = StPress;
                                key_code_d  = {low_idx(rs_q), low_idx(kpc_q)};
                                key_valid_d = 1'b1;
                                key_held_d  = 1'b1;
                                rcnt_d      = 4'd0;
                            end else begin
                                state_d = StDeb;
                            end
                        end else begin
                            kpc_d = kpc_rot;
                        end
                    end
                end
                StDeb: begin
                    if (tick) begin
                        if (rs_q == row_l_q) begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q + 4'd1 == DebN) begin
                                state_d     = StPress;
                                key_code_d  = {low_idx(row_l_q), low_idx(kpc_q)};
                                key_valid_d = 1'b1;
                                key_held_d  = 1'b1;
                                rcnt_d      = 4'd0;
                            end
                        end else begin
                            cnt_d   = 4'd0;
                            state_d = StScan;
                            kpc_d   = kpc_rot;
                        end
                    end
                end
                StPress: begin
                    if (tick) begin
                        rcnt_d = rcnt_upd;
                        if (rel_done) key_held_d = 1'b0;
                    end
                    // The event is kept until accepted even if the key is already up.
                    if (key_valid_q && key_ready) begin
                        key_valid_d = 1'b0;
                        state_d     = (!key_held_q || rel_done) ? StScan : StHold;
                    end
                end
                StHold: begin
                    if (tick) begin
                        rcnt_d = rcnt_upd;
                        if (rel_done) begin
                            key_held_d = 1'b0;
                            state_d    = StScan;
                            kpc_d      = kpc_rot;
                        end
                    end
                end
                default: begin
                    state_d = StScan;
                    kpc_d   = KpcInit;
                end
            endcase
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q       <= 16'd0;
            state_q     <= StScan;
            kpc_q       <= KpcInit;
            row_l_q     <= 4'hF;
            cnt_q       <= 4'd0;
            rcnt_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            kpc_q       <= kpc_d;
            row_l_q     <= row_l_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kpc       = kpc_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model, directed timing checks and
// randomized presses, with key events checked by a queue-based scoreboard.
module tb_keypad_scan_ctrl;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 3;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       key_held;

    logic       key_down = 1'b0;
    int         key_r    = 0;
    int         key_c    = 0;
    logic       ghost    = 1'b0;
    int         ready_mode = 0;  // 0: low, 1: high, 2: random

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_q[$];
    logic       pend      = 1'b0;
    logic [3:0] pend_code = 4'd0;
    int         cur       = 0;
    logic       seen;

    keypad_scan_ctrl #(
        .SCAN_DIV(SD),
        .DEBOUNCE(DB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .kpr      (kpr),
        .kpc      (kpc),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kpr = 4'hF;
        if (ghost) kpr = 4'b1100;
        else if (key_down && kpc[key_c] == 1'b0) kpr[key_r] = 1'b0;
    end

    // Consumer ready, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       key_ready = 1'b0;
            1:       key_ready = 1'b1;
            default: key_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted event.
    always @(negedge clk) begin
        if (pend) begin
            chk("valid_held", 32'(key_valid), 32'd1);
            chk("code_stable", 32'(key_code), 32'(pend_code));
        end
        if (key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got code 0x%0h, expected no event", key_code);
            end else begin
                chk("key_code", 32'(key_code), 32'(exp_q.pop_front()));
            end
        end
        pend      = key_valid && !key_ready;
        pend_code = key_code;
    end

    // Expected column drive n cycles after reset when nothing is pressed.
    function automatic logic [3:0] exp_kpc(input int n);
        int col;
        logic [3:0] v;
        col = 3 - ((n / SD) % 4);
        v = 4'hF;
        v[col] = 1'b0;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        key_down = 1'b0;
        ghost    = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pend    = 1'b0;
        exp_q.delete();
        @(negedge clk);
        cur = 0;
    endtask

    task automatic adv_to(input int t);
        while (cur < t) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic wait_held(input logic lvl, input int lim, input string name);
        int k;
        k = 0;
        while (key_held !== lvl && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(key_held), 32'(lvl));
    endtask

    task automatic chk_reset_vals();
        chk("rst_kpc", 32'(kpc), 32'h7);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
    endtask

    initial begin
        // Reset and free scanning with no keys.
        ready_mode = 0;
        do_reset();
        chk_reset_vals();
        for (int n = 0; n < 20; n++) begin
            adv_to(n);
            chk("scan_kpc", 32'(kpc), 32'(exp_kpc(n)));
        end
        chk("scan_no_valid", 32'(key_valid), 32'd0);

        // Press row 0 on column 3 with the consumer always ready.
        ready_mode = 1;
        do_reset();
        key_r = 0; key_c = 3; key_down = 1'b1;
        exp_q.push_back(4'b0011);
        adv_to(SD * DB - 1);
        chk("press_not_yet", 32'(key_valid), 32'd0);
        adv_to(SD * DB);
        chk("press_valid", 32'(key_valid), 32'd1);
        chk("press_kpc_frozen", 32'(kpc), 32'h7);
        adv_to(SD * DB + 1);
        chk("press_pulse_end", 32'(key_valid), 32'd0);
        adv_to(16);
        key_down = 1'b0;
        adv_to(16 + SD * DB - 1);
        chk("held_before_rel", 32'(key_held), 32'd1);
        adv_to(16 + SD * DB);
        chk("held_after_rel", 32'(key_held), 32'd0);
        chk("kpc_resume", 32'(kpc), 32'hB);

        // Bounce: one matching tick, then released.
        ready_mode = 2;
        do_reset();
        key_r = 1; key_c = 3; key_down = 1'b1;
        adv_to(SD);
        key_down = 1'b0;
        adv_to(2 * SD - 1);
        chk("bounce_frozen", 32'(kpc), 32'h7);
        adv_to(2 * SD);
        chk("bounce_advance", 32'(kpc), 32'hB);
        seen = 1'b0;
        for (int n = 2 * SD; n < 40; n++) begin
            adv_to(n);
            seen = seen | key_valid;
        end
        chk("bounce_no_event", 32'(seen), 32'd0);

        // Release before acknowledge: the event survives and goes straight to SCAN.
        ready_mode = 0;
        do_reset();
        key_r = 2; key_c = 3; key_down = 1'b1;
        exp_q.push_back(4'b1011);
        adv_to(SD * DB);
        chk("late_valid", 32'(key_valid), 32'd1);
        chk("late_code", 32'(key_code), 32'hB);
        adv_to(16);
        key_down = 1'b0;
        adv_to(16 + SD * DB);
        chk("late_held_low", 32'(key_held), 32'd0);
        chk("late_valid_kept", 32'(key_valid), 32'd1);
        chk("late_code_kept", 32'(key_code), 32'hB);
        chk("late_kpc_frozen", 32'(kpc), 32'h7);
        ready_mode = 1;
        adv_to(29);
        chk("late_valid_pre_ack", 32'(key_valid), 32'd1);
        adv_to(30);
        chk("late_valid_acked", 32'(key_valid), 32'd0);
        adv_to(32);
        chk("late_kpc_scan", 32'(kpc), 32'hB);

        // Ghosting: two rows low counts as no press.
        ready_mode = 2;
        do_reset();
        ghost = 1'b1;
        for (int n = 2; n < 24; n += 4) begin
            adv_to(n);
            chk("ghost_kpc", 32'(kpc), 32'(exp_kpc(n)));
        end
        chk("ghost_no_valid", 32'(key_valid), 32'd0);
        ghost = 1'b0;

        // Reset while an event is pending discards it.
        ready_mode = 0;
        do_reset();
        key_r = 0; key_c = 3; key_down = 1'b1;
        exp_q.push_back(4'b0011);
        adv_to(SD * DB);
        chk("pend_valid", 32'(key_valid), 32'd1);
        adv_to(SD * DB + 2);
        do_reset();
        chk_reset_vals();
        ready_mode = 2;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            adv_to(n);
            seen = seen | key_valid;
        end
        chk("rst_event_lost", 32'(seen), 32'd0);

        // Randomized presses, hold times and consumer readiness.
        do_reset();
        for (int it = 0; it < 16; it++) begin
            key_r = int'($urandom_range(0, 3));
            key_c = int'($urandom_range(0, 3));
            exp_q.push_back({2'(key_r), 2'(key_c)});
            key_down = 1'b1;
            wait_held(1'b1, 200, "rand_press_held");
            chk("rand_press_col", 32'(kpc[key_c]), 32'd0);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            key_down = 1'b0;
            wait_held(1'b0, 200, "rand_release_held");
            ready_mode = 1;
            for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
            chk("rand_event_drained", 32'(exp_q.size()), 32'd0);
            ready_mode = 2;
        end
        repeat (40) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
